fsm_pattern_tx: RTL and testbench

Serial pattern transmitter: the sending end of the single-bit pattern links used by the team's pattern-detector FSMs. It accepts a W-bit pattern through a start/ready handshake and shifts it MSB-first onto the serial line `A`. It can repeat the pattern a programmable number of times, separated by idle gap bits. All outputs are Moore outputs, decoded from registered state only, so `A` can drive a detector's input directly.

---
 rtl/fsm_pattern_tx.sv | 115 +++++++++++
 tb/tb_fsm_pattern_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_pattern_tx.sv
// fsm_pattern_tx: serial pattern transmitter.
// Accepts a W-bit pattern on a start/ready handshake and shifts it MSB-first
// onto A. The pattern can be repeated several times with GAP idle bits
// between frames. All outputs are decoded from registered state only.
// The frame-count input is named repeat_count because "repeat" is a reserved
// word in SystemVerilog.
module fsm_pattern_tx #(
   parameter int W   = 3,
   parameter int GAP = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] pattern,
   input  logic [3:0]   repeat_count,
   output logic         ready,
   output logic         A,
   output logic         frame,
   output logic         done
);

   localparam int BW = $clog2(W);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
   localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  sr_q, sr_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [3:0]    frames_q, frames_d;
   logic [GW-1:0] gap_q, gap_d;

   // State and datapath registers; reset returns straight to IDLE with no
   // partial frame completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         sr_q     <= '0;
         bit_q    <= '0;
         frames_q <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         bit_q    <= bit_d;
         frames_q <= frames_d;
         gap_q    <= gap_d;
      end
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      bit_d    = bit_q;
      frames_d = frames_q;
      gap_d    = gap_q;
      ready    = 1'b0;
      A        = 1'b1;
      frame    = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               sr_d     = pattern;
               frames_d = (repeat_count == 4'd0) ? 4'd1 : repeat_count;
               bit_d    = '0;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            A     = sr_q[W-1];
            frame = 1'b1;
            // Rotating (not shifting) leaves the pattern intact for the next frame.
            sr_d  = {sr_q[W-2:0], sr_q[W-1]};
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
               frames_d = frames_q - 4'd1;
               if (frames_q == 4'd1) begin
                  state_d = S_DONE;
               end else if (GAP > 0) begin
                  state_d = S_GAP;
                  gap_d   = '0;
               end else begin
                  bit_d = '0;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_SHIFT;
               bit_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Testbench for fsm_pattern_tx: two instances (GAP=1 and GAP=0) share the
// clock, reset, pattern and frame count; each has its own start so that held
// starts end at the right cycle. Expected per-cycle outputs are queued per
// instance when a transfer is launched and popped as the DUT produces them.
module tb_fsm_pattern_tx;

   typedef struct packed {
      logic a;
      logic frame;
      logic done;
      logic ready;
   } outT;

   logic       clk = 1'b0;
   logic       reset;
   logic       start1, start0;
   logic [2:0] pattern;
   logic [3:0] repeatCount;
   logic       ready1, a1, frame1, done1;
   logic       ready0, a0, frame0, done0;

   outT expQ1[$];
   outT expQ0[$];
   int  totalCount = 0;
   int  passCount  = 0;
   int  failCount  = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   fsm_pattern_tx #(.W(3), .GAP(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .pattern(pattern),
      .repeat_count(repeatCount), .ready(ready1), .A(a1), .frame(frame1), .done(done1)
   );

   fsm_pattern_tx #(.W(3), .GAP(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .pattern(pattern),
      .repeat_count(repeatCount), .ready(ready0), .A(a0), .frame(frame0), .done(done0)
   );

   function automatic void pushOne(input int gap, input outT e);
      if (gap == 1) expQ1.push_back(e);
      else expQ0.push_back(e);
   endfunction

   // Expected cycle-by-cycle outputs of one transfer: bits, gaps, DONE, IDLE.
   function automatic void pushTransfer(input int gap, input logic [2:0] pat, input int rep);
      int  frames;
      outT e;
      frames = (rep == 0) ? 1 : rep;
      for (int f = 0; f < frames; f++) begin
         for (int b = 0; b < 3; b++) begin
            e.a = pat[2-b]; e.frame = 1'b1; e.done = 1'b0; e.ready = 1'b0;
            pushOne(gap, e);
         end
         if (f < frames - 1) begin
            for (int g = 0; g < gap; g++) begin
               e = 4'b1000;
               pushOne(gap, e);
            end
         end
      end
      e = 4'b1010;
      pushOne(gap, e);
      e = 4'b1001;
      pushOne(gap, e);
   endfunction

   function automatic void queueBoth(input logic [2:0] pat, input int rep);
      pushTransfer(1, pat, rep);
      pushTransfer(0, pat, rep);
   endfunction

   task automatic checkOutput(input string tag, input outT obs, input outT exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed a/frame/done/ready=%b required %b", tag, obs, exp);
      end
   endtask

   // Launches a transfer on both DUTs and drains both scoreboards. With multi
   // set, start stays high until each DUT's final IDLE cycle; with busy set,
   // pattern and frame count are disturbed while the transfer is running.
   task automatic applyStimulus(input logic [2:0] pat, input int rep, input bit multi,
                                input bit busy, input string name);
      int  len1, len0, c;
      outT e;
      len1 = expQ1.size();
      len0 = expQ0.size();
      pattern = pat;
      repeatCount = rep[3:0];
      start1 = 1'b1;
      start0 = 1'b1;
      c = 0;
      while ((expQ1.size() > 0 || expQ0.size() > 0) && c < 200) begin
         @(posedge clk);
         #1;
         if (busy) begin
            pattern = 3'b110;
            repeatCount = 4'd5;
         end
         if (expQ1.size() > 0) begin
            e = expQ1.pop_front();
            checkOutput($sformatf("%s gap1 cyc%0d", name, c), {a1, frame1, done1, ready1}, e);
         end
         if (expQ0.size() > 0) begin
            e = expQ0.pop_front();
            checkOutput($sformatf("%s gap0 cyc%0d", name, c), {a0, frame0, done0, ready0}, e);
         end
         start1 = multi && (c < len1 - 1);
         start0 = multi && (c < len0 - 1);
         c++;
      end
      totalCount++;
      assert (expQ1.size() == 0 && expQ0.size() == 0) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s timeout: pending %0d/%0d required 0/0", name, expQ1.size(), expQ0.size());
      end
   endtask

   initial begin
      reset = 1'b0;
      start1 = 1'b0;
      start0 = 1'b0;
      pattern = 3'b000;
      repeatCount = 4'd0;
      #12;
      checkOutput("reset gap1", {a1, frame1, done1, ready1}, 4'b1001);
      checkOutput("reset gap0", {a0, frame0, done0, ready0}, 4'b1001);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      queueBoth(3'b001, 1);
      applyStimulus(3'b001, 1, 1'b0, 1'b0, "single");

      queueBoth(3'b101, 3);
      applyStimulus(3'b101, 3, 1'b0, 1'b0, "repeat3");

      queueBoth(3'b010, 2);
      applyStimulus(3'b010, 2, 1'b0, 1'b0, "repeat2");

      queueBoth(3'b100, 0);
      applyStimulus(3'b100, 0, 1'b0, 1'b0, "repeat0");

      queueBoth(3'b011, 2);
      applyStimulus(3'b011, 2, 1'b1, 1'b1, "busy");

      queueBoth(3'b101, 1);
      queueBoth(3'b101, 1);
      applyStimulus(3'b101, 1, 1'b1, 1'b0, "backtoback");

      // Reset during the second bit of a frame.
      pattern = 3'b101;
      repeatCount = 4'd1;
      start1 = 1'b1;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start0 = 1'b0;
      checkOutput("midreset bit0 gap1", {a1, frame1, done1, ready1}, 4'b1100);
      @(posedge clk);
      #1;
      checkOutput("midreset bit1 gap1", {a1, frame1, done1, ready1}, 4'b0100);
      checkOutput("midreset bit1 gap0", {a0, frame0, done0, ready0}, 4'b0100);
      reset = 1'b0;
      #1;
      checkOutput("midreset async gap1", {a1, frame1, done1, ready1}, 4'b1001);
      checkOutput("midreset async gap0", {a0, frame0, done0, ready0}, 4'b1001);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      queueBoth(3'b101, 1);
      applyStimulus(3'b101, 1, 1'b0, 1'b0, "afterreset");

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
